stim_controller: RTL and testbench

Parametrised successor to the fixed three-feature stimulation controller. Accepts NFEAT signed feature streams (line length, power, nonlinear energy, and future filters) with independent valid strobes. Each feature is compared against a run-time threshold, and the per-window results are combined under a selectable vote mode. Stimulation fires after CONSEC_WIN consecutive positive windows and is followed by a programmable pulse width and a refractory lock-out; the block sits at the end of the datapath after the feature modules.

---
 rtl/stim_pkg.sv | 20 ++
 rtl/feature_gate.sv | 46 ++++
 rtl/stim_controller.sv | 154 +++++++++++++++
 tb/tb_stim_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared encodings and sizing helper for the stimulation controller.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        STIM = 2'd2,
        REFR = 2'd3
    } state_t;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_MAJ = 2'd2;

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/feature_gate.sv
// One feature lane: signed threshold compare, flag/fresh capture and overrun tracking.
module feature_gate #(
    parameter int FEAT_WIDTH = 40
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic                  i_clr,
    input  logic [FEAT_WIDTH-1:0] i_din,
    input  logic [FEAT_WIDTH-1:0] i_thr,
    output logic                  o_flag,
    output logic                  o_fresh,
    output logic                  o_ovr
);

    logic r_flag;
    logic r_fresh;
    logic r_ovr;
    logic w_gt;

    assign w_gt = $signed(i_din) > $signed(i_thr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flag  <= 1'b0;
            r_fresh <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (!i_en) begin
            if (i_valid) begin
                r_flag  <= w_gt;
                r_fresh <= 1'b1;
                // A sample consumed by this cycle's window is not lost, so no overrun then.
                if (r_fresh && !i_clr)
                    r_ovr <= 1'b1;
            end else if (i_clr) begin
                r_fresh <= 1'b0;
            end
        end
    end

    assign o_flag  = r_flag;
    assign o_fresh = r_fresh;
    assign o_ovr   = r_ovr;

endmodule

// File: rtl/stim_controller.sv
// Window voting over NFEAT feature gates, consecutive-window FSM, timed pulse and refractory.
module stim_controller
    import stim_pkg::*;
#(
    parameter int NFEAT          = 3,
    parameter int FEAT_WIDTH     = 40,
    parameter int VOTE_MIN       = 2,
    parameter int CONSEC_WIN     = 4,
    parameter int STIM_CYCLES    = 1000,
    parameter int REFRACT_CYCLES = 5000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [NFEAT*FEAT_WIDTH-1:0]     din,
    input  logic [NFEAT-1:0]                data_valid,
    input  logic [NFEAT*FEAT_WIDTH-1:0]     thr,
    input  logic [1:0]                      mode,
    output logic                            stimulation,
    output logic                            detect,
    output logic [1:0]                      state,
    output logic [$clog2(CONSEC_WIN+1)-1:0] win_count,
    output logic                            overrun
);

    localparam int WW      = $clog2(CONSEC_WIN + 1);
    localparam int CNT_MAX = (STIM_CYCLES > REFRACT_CYCLES) ? STIM_CYCLES : REFRACT_CYCLES;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] STIM_LAST = CW'(STIM_CYCLES - 1);
    localparam logic [CW-1:0] REFR_LAST = CW'((REFRACT_CYCLES > 0) ? REFRACT_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WIN_LAST  = WW'(CONSEC_WIN - 1);
    localparam logic [3:0]    NF4       = 4'(NFEAT);
    localparam logic [3:0]    VM4       = 4'(VOTE_MIN);

    logic [NFEAT-1:0] w_flag;
    logic [NFEAT-1:0] w_fresh;
    logic [NFEAT-1:0] w_ovr;
    logic             w_eval;
    logic             w_pos;
    logic [3:0]       w_pop;

    state_t        r_state, w_nxt_state;
    logic [WW-1:0] r_win,   w_nxt_win;
    logic [CW-1:0] r_cnt,   w_nxt_cnt;
    logic          r_stim,  w_nxt_stim;
    logic          r_det,   w_nxt_det;

    function automatic logic [3:0] popcount(input logic [NFEAT-1:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < NFEAT; i++)
            s = s + {3'b000, v[i]};
        return s;
    endfunction

    assign w_eval = (&w_fresh) && !en;

    for (genvar g = 0; g < NFEAT; g++) begin : g_gate
        feature_gate #(
            .FEAT_WIDTH(FEAT_WIDTH)
        ) u_gate (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_en    (en),
            .i_valid (data_valid[g]),
            .i_clr   (w_eval),
            .i_din   (din[g*FEAT_WIDTH +: FEAT_WIDTH]),
            .i_thr   (thr[g*FEAT_WIDTH +: FEAT_WIDTH]),
            .o_flag  (w_flag[g]),
            .o_fresh (w_fresh[g]),
            .o_ovr   (w_ovr[g])
        );
    end

    assign w_pop = popcount(w_flag);

    always_comb begin
        case (mode)
            MODE_OR:  w_pos = (w_pop >= 4'd1);
            MODE_MAJ: w_pos = (w_pop >= VM4);
            default:  w_pos = (w_pop == NF4);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_cnt   <= '0;
            r_stim  <= 1'b0;
            r_det   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_win   <= w_nxt_win;
            r_cnt   <= w_nxt_cnt;
            r_stim  <= w_nxt_stim;
            r_det   <= w_nxt_det;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_win   = r_win;
        w_nxt_cnt   = r_cnt;
        w_nxt_stim  = r_stim;
        w_nxt_det   = 1'b0;
        if (!en) begin
            case (r_state)
                IDLE, PEND: begin
                    if (w_eval && w_pos) begin
                        w_nxt_det = 1'b1;
                        if (r_state == PEND && r_win != WIN_LAST || r_state == IDLE && CONSEC_WIN > 1) begin
                            w_nxt_state = PEND;
                            w_nxt_win   = r_win + WW'(1);
                        end else begin
                            w_nxt_state = STIM;
                            w_nxt_win   = '0;
                            w_nxt_cnt   = '0;
                            w_nxt_stim  = 1'b1;
                        end
                    end else if (w_eval && r_state == PEND) begin
                        w_nxt_state = IDLE;
                        w_nxt_win   = '0;
                    end
                end
                STIM: begin
                    if (r_cnt == STIM_LAST) begin
                        w_nxt_stim  = 1'b0;
                        w_nxt_cnt   = '0;
                        w_nxt_state = (REFRACT_CYCLES == 0) ? IDLE : REFR;
                    end else begin
                        w_nxt_cnt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    // Windows still drain here; their decisions are deliberately dropped.
                    if (r_cnt == REFR_LAST) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_cnt = r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign stimulation = r_stim;
    assign detect      = r_det;
    assign state       = r_state;
    assign win_count   = r_win;
    assign overrun     = |w_ovr;

endmodule

// File: tb/tb_stim_controller.sv
// Directed bench for stim_controller: voting modes, FSM timing, overrun, enable freeze and async reset.
module tb_stim_controller;

    localparam int FW = 40;
    localparam logic signed [FW-1:0] HI = 40'sd200;
    localparam logic signed [FW-1:0] LO = 40'sd50;

    logic              clk;
    logic              rst;
    logic              en;
    logic [3*FW-1:0]   din;
    logic [2:0]        data_valid;
    logic [3*FW-1:0]   thr;
    logic [1:0]        mode;
    logic              stimulation;
    logic              detect;
    logic [1:0]        state;
    logic [1:0]        win_count;
    logic              overrun;

    logic signed [FW-1:0] d0, d1, d2;
    logic signed [FW-1:0] t0, t1, t2;

    int total = 0;
    int bad   = 0;

    assign din = {d2, d1, d0};
    assign thr = {t2, t1, t0};

    stim_controller #(
        .NFEAT(3), .FEAT_WIDTH(FW), .VOTE_MIN(2), .CONSEC_WIN(2),
        .STIM_CYCLES(4), .REFRACT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .data_valid(data_valid),
        .thr(thr), .mode(mode), .stimulation(stimulation), .detect(detect),
        .state(state), .win_count(win_count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v, input logic signed [FW-1:0] a,
                        input logic signed [FW-1:0] b, input logic signed [FW-1:0] c);
        d0 = a; d1 = b; d2 = c;
        data_valid = v;
        step();
        data_valid = 3'b000;
    endtask

    task automatic win(input logic [2:0] p);
        send(3'b111, p[0] ? HI : LO, p[1] ? HI : LO, p[2] ? HI : LO);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data_valid = 3'b000; mode = 2'd0;
        d0 = '0; d1 = '0; d2 = '0;
        t0 = 40'sd100; t1 = 40'sd100; t2 = 40'sd100;
        #3;
        chk("rst_stim", stimulation, 0);
        chk("rst_det", detect, 0);
        chk("rst_state", state, 0);
        chk("rst_win", win_count, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk); rst = 1'b0;
        step();

        // OR mode: two positive windows -> STIM(4) -> REFR(3) -> IDLE
        win(3'b001); step();
        chk("or_w1_det", detect, 1);
        chk("or_w1_state", state, 1);
        chk("or_w1_win", win_count, 1);
        win(3'b001); step();
        chk("or_w2_det", detect, 1);
        chk("or_w2_state", state, 2);
        chk("or_w2_stim", stimulation, 1);
        chk("or_w2_win", win_count, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stim_hold", stimulation, 1);
            chk("stim_state", state, 2);
        end
        step();
        chk("stim_end", stimulation, 0);
        chk("refr_enter", state, 3);
        win(3'b111);
        chk("refr_c2", state, 3);
        step();
        chk("refr_det", detect, 0);
        chk("refr_c3", state, 3);
        chk("refr_stim", stimulation, 0);
        step();
        chk("refr_exit", state, 0);
        chk("refr_exit_det", detect, 0);

        // MAJ / AND voting
        mode = 2'd2;
        win(3'b001); step();
        chk("maj1_det", detect, 0);
        chk("maj1_state", state, 0);
        win(3'b011); step();
        chk("maj2_det", detect, 1);
        chk("maj2_state", state, 1);
        mode = 2'd1;
        win(3'b011); step();
        chk("and2_det", detect, 0);
        chk("pend_neg_state", state, 0);
        chk("pend_neg_win", win_count, 0);
        mode = 2'd0;
        win(3'b100); step();
        chk("repos_win", win_count, 1);
        chk("repos_state", state, 1);

        // Signed compare: 5 > -10 positive, -20 > 100 negative
        win(3'b000); step();
        chk("back_idle", state, 0);
        t2 = -40'sd10;
        send(3'b111, -40'sd20, LO, 40'sd5); step();
        chk("signed_pos", detect, 1);
        t2 = 40'sd100;
        send(3'b111, -40'sd20, LO, LO); step();
        chk("signed_neg", detect, 0);
        chk("signed_neg_state", state, 0);

        // Overrun: second sample on feature 1 replaces the first
        send(3'b010, LO, HI, LO);
        chk("ovr_pre", overrun, 0);
        send(3'b010, LO, LO, LO);
        chk("ovr_set", overrun, 1);
        send(3'b101, LO, LO, LO); step();
        chk("ovr_latest", detect, 0);
        chk("ovr_sticky", overrun, 1);

        // Valid landing in the evaluation cycle seeds the next window
        win(3'b000);
        send(3'b001, HI, LO, LO);
        send(3'b110, LO, LO, LO); step();
        chk("evalvalid_det", detect, 1);
        chk("evalvalid_state", state, 1);
        win(3'b000); step();
        chk("evalvalid_idle", state, 0);

        // Enable freeze mid-STIM
        win(3'b001); step();
        win(3'b001); step();
        chk("frz_stim_start", stimulation, 1);
        step();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_stim", stimulation, 1);
            chk("frz_state", state, 2);
            chk("frz_det", detect, 0);
        end
        en = 1'b0;
        step();
        chk("frz_rem1", stimulation, 1);
        step();
        chk("frz_rem2", stimulation, 1);
        step();
        chk("frz_end", stimulation, 0);
        chk("frz_refr", state, 3);
        repeat (3) step();
        chk("frz_idle", state, 0);

        // Asynchronous reset mid-STIM
        win(3'b001); step();
        win(3'b001); step();
        step();
        chk("ar_pre", stimulation, 1);
        rst = 1'b1;
        #1;
        chk("ar_stim", stimulation, 0);
        chk("ar_state", state, 0);
        chk("ar_ovr", overrun, 0);
        chk("ar_win", win_count, 0);
        chk("ar_det", detect, 0);
        #2 rst = 1'b0;
        step();
        chk("ar_resume", state, 0);
        win(3'b001); step();
        chk("ar_after_det", detect, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
